ac_interval_update: RTL and testbench

//  Arithmetic-encoder interval update: computes new upper and lower bounds together in one

---
 rtl/ac_interval_update.sv | 146 ++++++++++++++
 tb/tb_ac_interval_update.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ac_interval_update.sv
// ac_interval_update: arithmetic-encoder interval update.
//
// Computes the new upper and lower bounds of the coding interval for one
// symbol per accepted beat, in a fixed 5-stage pipeline:
//   new_hi = (work_lo - SUB_HI + floor(r*cum_hi*inv_total / 2^W)) mod 2^W
//   new_lo = (work_lo - SUB_LO + floor(r*cum_lo*inv_total / 2^W)) mod 2^W
// where r = work_hi - work_lo + 1, held at W+1 bits.
// out_err flags a degenerate interval: inverted input bounds or inverted results.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    input handshake (in_ready = !out_valid | out_ready)
//   work_hi, work_lo       current interval bounds (W bits)
//   cum_hi, cum_lo         cumulative frequency edges of the symbol (W bits)
//   inv_total              reciprocal of total count scaled by 2^W (W+1 bits)
//   in_tag / out_tag       sideband tag carried with each beat
//   out_valid / out_ready  output handshake
//   new_hi, new_lo         updated bounds
//   out_err                degenerate-interval flag for this beat
module ac_interval_update #(
  parameter int unsigned W      = 16,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned SUB_HI = 1,
  parameter int unsigned SUB_LO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     work_hi,
  input  logic [W-1:0]     work_lo,
  input  logic [W-1:0]     cum_hi,
  input  logic [W-1:0]     cum_lo,
  input  logic [W:0]       inv_total,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     new_hi,
  output logic [W-1:0]     new_lo,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned RcW   = 2 * W + 1;  // r * cum
  localparam int unsigned PW    = 3 * W + 2;  // r * cum * inv_total
  localparam logic [W-1:0] SubHi = W'(SUB_HI);
  localparam logic [W-1:0] SubLo = W'(SUB_LO);
  localparam logic [W:0]   One   = (W+1)'(1);

  logic en;
  logic [4:0] vld;  // vld[k] is the valid bit of stage k+1

  // Stage 1: registered inputs and interval range
  logic [W:0]       s1_r;
  logic [W-1:0]     s1_cum_hi, s1_cum_lo, s1_lo;
  logic [W:0]       s1_inv;
  logic             s1_err;
  logic [TAG_W-1:0] s1_tag;
  // Stage 2: r * cum
  logic [RcW-1:0]   s2_rc_hi, s2_rc_lo;
  logic [W:0]       s2_inv;
  logic [W-1:0]     s2_lo;
  logic             s2_err;
  logic [TAG_W-1:0] s2_tag;
  // Stage 3: partials against inv_total split into low W bits and the top bit
  logic [PW-1:0]    s3_pa_hi, s3_pa_lo;
  logic [RcW-1:0]   s3_pb_hi, s3_pb_lo;
  logic [W-1:0]     s3_lo;
  logic             s3_err;
  logic [TAG_W-1:0] s3_tag;
  // Stage 4: scaled quotient and offset lower bound
  logic [W-1:0]     s4_q_hi, s4_q_lo, s4_base_hi, s4_base_lo;
  logic             s4_err;
  logic [TAG_W-1:0] s4_tag;

  logic [PW-1:0]    sum_hi, sum_lo;
  logic [W-1:0]     nh, nl;
  logic             unused_sum;

  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = vld[4];

  always_comb begin
    sum_hi = s3_pa_hi + (PW'(s3_pb_hi) << W);
    sum_lo = s3_pa_lo + (PW'(s3_pb_lo) << W);
    nh     = s4_base_hi + s4_q_hi;
    nl     = s4_base_lo + s4_q_lo;
  end

  // Only bits [2W-1:W] of the full product survive the >>W and the mod 2^W.
  assign unused_sum = ^{sum_hi[PW-1:2*W], sum_hi[W-1:0], sum_lo[PW-1:2*W], sum_lo[W-1:0]};

  // Valid chain and output register: reset to zero, held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld     <= '0;
      new_hi  <= '0;
      new_lo  <= '0;
      out_err <= 1'b0;
      out_tag <= '0;
    end else if (en) begin
      vld     <= {vld[3:0], in_valid};
      new_hi  <= nh;
      new_lo  <= nl;
      out_err <= s4_err | (nh < nl);
      out_tag <= s4_tag;
    end
  end

  // Internal datapath: no reset needed, qualified by the valid chain.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_r      <= {1'b0, work_hi} - {1'b0, work_lo} + One;
      s1_cum_hi <= cum_hi;
      s1_cum_lo <= cum_lo;
      s1_lo     <= work_lo;
      s1_inv    <= inv_total;
      s1_err    <= work_hi < work_lo;
      s1_tag    <= in_tag;

      s2_rc_hi  <= RcW'(s1_r) * RcW'(s1_cum_hi);
      s2_rc_lo  <= RcW'(s1_r) * RcW'(s1_cum_lo);
      s2_inv    <= s1_inv;
      s2_lo     <= s1_lo;
      s2_err    <= s1_err;
      s2_tag    <= s1_tag;

      s3_pa_hi  <= PW'(s2_rc_hi) * PW'(s2_inv[W-1:0]);
      s3_pa_lo  <= PW'(s2_rc_lo) * PW'(s2_inv[W-1:0]);
      s3_pb_hi  <= s2_inv[W] ? s2_rc_hi : '0;
      s3_pb_lo  <= s2_inv[W] ? s2_rc_lo : '0;
      s3_lo     <= s2_lo;
      s3_err    <= s2_err;
      s3_tag    <= s2_tag;

      s4_q_hi    <= sum_hi[2*W-1:W];
      s4_q_lo    <= sum_lo[2*W-1:W];
      s4_base_hi <= s3_lo - SubHi;
      s4_base_lo <= s3_lo - SubLo;
      s4_err     <= s3_err;
      s4_tag     <= s3_tag;
    end
  end

endmodule

// File: tb/tb_ac_interval_update.sv
// Bench for ac_interval_update (W=16, TAG_W=4, SUB_HI=1, SUB_LO=0).
module tb_ac_interval_update;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] work_hi, work_lo, cum_hi, cum_lo;
  logic [16:0] inv_total;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] new_hi, new_lo;
  logic        out_err;
  logic [3:0]  out_tag;

  ac_interval_update #(.W(16), .TAG_W(4), .SUB_HI(1), .SUB_LO(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .work_hi   (work_hi),
    .work_lo   (work_lo),
    .cum_hi    (cum_hi),
    .cum_lo    (cum_lo),
    .inv_total (inv_total),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .new_hi    (new_hi),
    .new_lo    (new_lo),
    .out_err   (out_err),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: the interval formulas evaluated directly in 64-bit arithmetic.
  function automatic exp_t model(input logic [15:0] wh, input logic [15:0] wl,
                                 input logic [15:0] ch, input logic [15:0] cl,
                                 input logic [16:0] inv, input logic [3:0] tag);
    logic [63:0] r, qh, ql;
    exp_t e;
    r     = ({48'd0, wh} - {48'd0, wl} + 64'd1) % 64'h2_0000;
    qh    = (r * {48'd0, ch} * {47'd0, inv}) / 64'h1_0000;
    ql    = (r * {48'd0, cl} * {47'd0, inv}) / 64'h1_0000;
    e.hi  = 16'(({48'd0, wl} + 64'h1_0000 - 64'd1 + qh) % 64'h1_0000);
    e.lo  = 16'(({48'd0, wl} + ql) % 64'h1_0000);
    e.err = (wh < wl) || (e.hi < e.lo);
    e.tag = tag;
    return e;
  endfunction

  // One clock cycle: score the handshakes seen before the edge, then check stall hold.
  task automatic cyc(output logic acc);
    logic emit, stall;
    exp_t e, held;
    #1;
    acc   = in_valid & in_ready;
    emit  = out_valid & out_ready;
    stall = out_valid & ~out_ready;
    held  = '{hi: new_hi, lo: new_lo, err: out_err, tag: out_tag};
    if (emit) begin
      if (q.size() == 0) chk("spurious_beat", {63'd0, out_valid}, 64'd0);
      else begin
        e = q.pop_front();
        chk("beat_hi", {48'd0, new_hi}, {48'd0, e.hi});
        chk("beat_lo", {48'd0, new_lo}, {48'd0, e.lo});
        chk("beat_err", {63'd0, out_err}, {63'd0, e.err});
        chk("beat_tag", {60'd0, out_tag}, {60'd0, e.tag});
      end
    end
    if (acc) q.push_back(model(work_hi, work_lo, cum_hi, cum_lo, inv_total, in_tag));
    @(posedge clk);
    #1;
    if (stall)
      chk("stall_hold", {26'd0, out_valid, new_hi, new_lo, out_err, out_tag},
          {26'd0, 1'b1, held.hi, held.lo, held.err, held.tag});
  endtask

  task automatic set_beat(input logic [15:0] wh, input logic [15:0] wl, input logic [15:0] ch,
                          input logic [15:0] cl, input logic [16:0] inv, input logic [3:0] tag);
    work_hi = wh; work_lo = wl; cum_hi = ch; cum_lo = cl; inv_total = inv; in_tag = tag;
    in_valid = 1'b1;
  endtask

  // Single beat with out_ready high; checks latency and the expected result constants.
  task automatic run_one(input string name, input logic [15:0] wh, input logic [15:0] wl,
                         input logic [15:0] ch, input logic [15:0] cl,
                         input logic [15:0] eh, input logic [15:0] el, input logic ee);
    logic acc;
    int   k;
    out_ready = 1'b1;
    set_beat(wh, wl, ch, cl, 17'h0_4000, 4'(n_vec));
    cyc(acc);
    chk({name, "_accept"}, {63'd0, acc}, 64'd1);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 20) begin
      cyc(acc);
      k++;
    end
    chk({name, "_latency"}, 64'(k), 64'd5);
    chk({name, "_hi"}, {48'd0, new_hi}, {48'd0, eh});
    chk({name, "_lo"}, {48'd0, new_lo}, {48'd0, el});
    chk({name, "_err"}, {63'd0, out_err}, {63'd0, ee});
    cyc(acc);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_state"}, {28'd0, out_valid, new_hi, new_lo, out_err, out_tag}, 64'd0);
    chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic acc;
    logic [15:0] a, b;
    int guard;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    work_hi = '0; work_lo = '0; cum_hi = '0; cum_lo = '0; inv_total = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("reset");

    run_one("t1", 16'hFFFF, 16'h0000, 16'd2, 16'd1, 16'h7FFF, 16'h4000, 1'b0);
    run_one("t2", 16'h1FFF, 16'h1000, 16'd4, 16'd0, 16'h1FFF, 16'h1000, 1'b0);
    run_one("t3", 16'h1FFF, 16'h1000, 16'd0, 16'd0, 16'h0FFF, 16'h1000, 1'b1);

    // Inverted input interval between two healthy neighbours, back to back.
    out_ready = 1'b1;
    set_beat(16'hFFFF, 16'h0000, 16'd2, 16'd1, 17'h0_4000, 4'd1); cyc(acc);
    set_beat(16'h0100, 16'h0200, 16'd2, 16'd1, 17'h0_4000, 4'd2); cyc(acc);
    set_beat(16'hFFFF, 16'h0000, 16'd2, 16'd1, 17'h0_4000, 4'd3); cyc(acc);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin cyc(acc); guard++; end
    chk("t6_err_before", {63'd0, out_err}, 64'd0); cyc(acc);
    chk("t6_err_bad", {63'd0, out_err}, 64'd1); cyc(acc);
    chk("t6_err_after", {63'd0, out_err}, 64'd0); cyc(acc);

    // total = 1 boundary through the model.
    set_beat(16'h8000, 16'h0010, 16'd1, 16'd0, 17'h1_0000, 4'd9); cyc(acc);
    in_valid = 1'b0;

    // Random beats with random backpressure.
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 16'($urandom) : a + 16'($urandom_range(0, 65535 - a));
      cum_lo = 16'($urandom);
      set_beat(b, a, cum_lo + 16'($urandom_range(0, 65535 - cum_lo)), cum_lo,
               17'($urandom_range(0, 65536)), 4'($urandom));
      guard = 0;
      do begin
        out_ready = ($urandom_range(0, 9) >= 4);
        cyc(acc);
        guard++;
      end while (!acc && guard < 50);
      if (!acc) chk("rand_accept_timeout", 64'd0, 64'd1);
    end
    in_valid = 1'b0;
    guard = 0;
    while (q.size() != 0 && guard < 300) begin
      out_ready = ($urandom_range(0, 9) >= 4);
      cyc(acc);
      guard++;
    end
    chk("rand_drain", 64'(q.size()), 64'd0);

    // Reset with a full pipe: nothing in flight may come out.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_beat(16'hFFFF, 16'h0000, 16'd2, 16'd1, 17'h0_4000, 4'(i + 1));
      cyc(acc);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    chk_zero("mid_reset");
    for (int i = 0; i < 10; i++) cyc(acc);
    chk("post_reset_idle", {63'd0, out_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
